// File: rtl/i2s_rx_dsp_packer.sv
// DSP-mode I2S RX packer: packs 8/16/32-bit samples into 32-bit words and
// buffers them in a small first-word-fall-through FIFO. Never back-pressures.
module i2s_rx_dsp_packer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       sck_i,
  input  logic                       rst_i,
  input  logic                       cfg_en_i,
  input  logic [1:0]                 cfg_pack_mode_i,
  input  logic                       err_clr_i,
  input  logic [31:0]                in_data_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [31:0]                out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [1:0]    mode_eff, mode_q, lane_q, lane_cur, lane_d, last_lane;
  logic [31:0]   asm_q, asm_cur, asm_d, lane_word, merged;
  logic          mode_chg, accept, push;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          empty, full, pop, wr_en, overflow;

  assign in_ready_o = cfg_en_i;
  assign accept     = in_valid_i & cfg_en_i;

  // Lane placement and word assembly; a mode change restarts the word at lane 0
  always_comb begin
    mode_eff  = (cfg_pack_mode_i == 2'd3) ? 2'd0 : cfg_pack_mode_i;
    mode_chg  = (mode_eff != mode_q);
    lane_cur  = mode_chg ? 2'd0 : lane_q;
    asm_cur   = mode_chg ? 32'd0 : asm_q;
    last_lane = 2'd0;
    lane_word = in_data_i;
    case (mode_eff)
      2'd1: begin
        last_lane = 2'd1;
        lane_word = {16'h0, in_data_i[15:0]} << {lane_cur, 4'b0000};
      end
      2'd2: begin
        last_lane = 2'd3;
        lane_word = {24'h0, in_data_i[7:0]} << {lane_cur, 3'b000};
      end
      default: begin
        last_lane = 2'd0;
        lane_word = in_data_i;
      end
    endcase
    merged = asm_cur | lane_word;
    push   = accept & (lane_cur == last_lane);
    lane_d = lane_cur;
    asm_d  = asm_cur;
    if (!cfg_en_i) begin
      lane_d = 2'd0;
      asm_d  = 32'd0;
    end else if (accept) begin
      lane_d = push ? 2'd0 : lane_cur + 2'd1;
      asm_d  = push ? 32'd0 : merged;
    end
  end

  // FIFO control; a push into a full FIFO survives only if a pop frees a slot
  always_comb begin
    empty    = (count_q == LW'(0));
    full     = (count_q == LW'(DEPTH));
    pop      = ~empty & out_ready_i;
    wr_en    = push & (~full | pop);
    overflow = push & full & ~pop;
    count_d  = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
    err_d = overflow | (err_q & ~err_clr_i);
  end

  always_ff @(posedge sck_i) begin
    if (rst_i) begin
      mode_q   <= 2'd0;
      lane_q   <= 2'd0;
      asm_q    <= 32'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'd0;
    end else begin
      mode_q  <= mode_eff;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (wr_en) begin
        mem[wr_ptr_q] <= merged;
        wr_ptr_q      <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  assign out_valid_o = ~empty;
  assign out_data_o  = empty ? 32'd0 : mem[rd_ptr_q];
  assign level_o     = count_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_i2s_rx_dsp_packer.sv
// Directed bench for i2s_rx_dsp_packer with DEPTH=4.
module tb_i2s_rx_dsp_packer;

  logic        sck_i = 1'b0;
  logic        rst_i;
  logic        cfg_en_i;
  logic [1:0]  cfg_pack_mode_i;
  logic        err_clr_i;
  logic [31:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [2:0]  level_o;
  logic        err_o;

  int vectors = 0;
  int miscompares = 0;

  i2s_rx_dsp_packer #(.DEPTH(4)) dut (
    .sck_i(sck_i), .rst_i(rst_i), .cfg_en_i(cfg_en_i),
    .cfg_pack_mode_i(cfg_pack_mode_i), .err_clr_i(err_clr_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .level_o(level_o), .err_o(err_o)
  );

  always #5 sck_i = ~sck_i;

  task automatic cyc();
    @(posedge sck_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d);
    in_valid_i = 1'b1;
    in_data_i  = d;
    cyc();
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
    cyc();
  endtask

  initial begin
    rst_i = 1'b1; cfg_en_i = 1'b0; cfg_pack_mode_i = 2'd0; err_clr_i = 1'b0;
    in_data_i = 32'd0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    cyc(); cyc();
    rst_i = 1'b0;
    cyc();
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_data",  out_data_o, 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_err",   32'(err_o), 32'd0);
    chk("rdy_dis",   32'(in_ready_o), 32'd0);

    // 2x16 packing
    cfg_en_i = 1'b1; cfg_pack_mode_i = 2'd1; out_ready_i = 1'b1;
    #1 chk("rdy_en", 32'(in_ready_o), 32'd1);
    send(32'h1111_AAAA);
    chk("m1_half_valid", 32'(out_valid_o), 32'd0);
    send(32'h2222_BBBB);
    chk("m1_valid", 32'(out_valid_o), 32'd1);
    chk("m1_data",  out_data_o, 32'hBBBB_AAAA);
    idle();
    chk("m1_drained", 32'(level_o), 32'd0);

    // 4x8 packing
    cfg_pack_mode_i = 2'd2;
    send(32'h11); send(32'h22); send(32'h33);
    chk("m2_lvl0", 32'(level_o), 32'd0);
    send(32'h44);
    chk("m2_lvl1", 32'(level_o), 32'd1);
    chk("m2_data", out_data_o, 32'h4433_2211);
    idle();
    chk("m2_lvl_end", 32'(level_o), 32'd0);

    // passthrough overflow, clear, push+pop at full, drain order
    cfg_pack_mode_i = 2'd0; out_ready_i = 1'b0;
    send(32'h100); send(32'h101); send(32'h102); send(32'h103);
    chk("full_lvl", 32'(level_o), 32'd4);
    chk("full_err", 32'(err_o), 32'd0);
    send(32'h104);
    chk("ovf_lvl",  32'(level_o), 32'd4);
    chk("ovf_err",  32'(err_o), 32'd1);
    chk("ovf_head", out_data_o, 32'h100);
    err_clr_i = 1'b1; idle(); err_clr_i = 1'b0;
    chk("clr_err",  32'(err_o), 32'd0);
    out_ready_i = 1'b1;
    send(32'h105);
    chk("pp_lvl",  32'(level_o), 32'd4);
    chk("pp_err",  32'(err_o), 32'd0);
    chk("pp_head", out_data_o, 32'h101);
    idle();
    chk("drain_h2", out_data_o, 32'h102);
    chk("drain_l3", 32'(level_o), 32'd3);
    idle();
    chk("drain_h3", out_data_o, 32'h103);
    idle();
    chk("drain_tail", out_data_o, 32'h105);
    chk("drain_l1", 32'(level_o), 32'd1);
    idle();
    chk("empty_lvl",   32'(level_o), 32'd0);
    chk("empty_data",  out_data_o, 32'd0);
    chk("empty_valid", 32'(out_valid_o), 32'd0);
    idle();
    chk("pop_empty_lvl", 32'(level_o), 32'd0);

    // clear coinciding with overflow: set wins
    out_ready_i = 1'b0;
    send(32'h200); send(32'h201); send(32'h202); send(32'h203);
    err_clr_i = 1'b1;
    send(32'h204);
    err_clr_i = 1'b0;
    chk("clr_ovf_err", 32'(err_o), 32'd1);
    idle();
    chk("err_sticky", 32'(err_o), 32'd1);

    // mid-operation reset
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    chk("mrst_lvl",   32'(level_o), 32'd0);
    chk("mrst_err",   32'(err_o), 32'd0);
    chk("mrst_valid", 32'(out_valid_o), 32'd0);
    chk("mrst_data",  out_data_o, 32'd0);

    // disable discards partial word
    cfg_pack_mode_i = 2'd2; out_ready_i = 1'b1;
    send(32'hB1); send(32'hB2); send(32'hB3);
    cfg_en_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'hEE;
    #1 chk("dis_rdy", 32'(in_ready_o), 32'd0);
    cyc();
    chk("dis_lvl", 32'(level_o), 32'd0);
    cfg_en_i = 1'b1;
    send(32'hA1); send(32'hA2); send(32'hA3);
    chk("en_lvl0", 32'(level_o), 32'd0);
    send(32'hA4);
    chk("en_data", out_data_o, 32'hA4A3_A2A1);
    chk("en_lvl1", 32'(level_o), 32'd1);
    idle();

    // mode change mid-word restarts at lane 0
    send(32'hC1); send(32'hC2);
    cfg_pack_mode_i = 2'd1;
    send(32'hFFFF_DDDD);
    chk("mc_lvl0", 32'(level_o), 32'd0);
    send(32'h1234_EEEE);
    chk("mc_data", out_data_o, 32'hEEEE_DDDD);
    idle();

    // reserved mode behaves as passthrough
    cfg_pack_mode_i = 2'd3;
    send(32'hDEAD_BEEF);
    chk("m3_data",  out_data_o, 32'hDEAD_BEEF);
    chk("m3_valid", 32'(out_valid_o), 32'd1);
    idle();
    chk("m3_empty", 32'(out_valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
